// File: rtl/score_uart_tx.sv
// Reports a 32-bit score as decimal ASCII followed by CR LF over an 8N1 UART.
// Binary-to-BCD uses a 32-step double-dabble; leading zeros are dropped before sending.

module score_uart_tx_dab (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module score_uart_tx #(
  parameter int CLK_HZ = 250000000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] score,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        tx
);
  localparam int CPB  = CLK_HZ / BAUD;
  localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int NDIG = 10;

  typedef enum logic [2:0] {IDLE, CONVERT, SELECT, START_BIT, DATA, STOP_BIT} state_t;

  state_t                      state;
  logic [31:0]                 bin;
  logic [NDIG-1:0][3:0]        bcd;
  logic [NDIG-1:0][3:0]        bcd_adj;
  logic [4*NDIG-1:0]           bcd_flat;
  logic [4:0]                  step;
  logic [CW-1:0]               cnt;
  logic [2:0]                  bitn;
  logic [3:0]                  bidx;
  logic [3:0]                  ndig;
  logic [3:0]                  nd_sel;
  logic [7:0]                  sh;
  logic                        fin;
  logic                        bit_end;

  // One +3 corrector per BCD digit, all applied before the shared shift.
  for (genvar g = 0; g < NDIG; g++) begin : g_dab
    score_uart_tx_dab u_dab (.d(bcd[g]), .q(bcd_adj[g]));
  end

  assign bcd_flat = bcd_adj;
  assign bit_end  = (cnt == CW'(CPB - 1));

  // Number of significant digits; a zero value still prints one digit.
  always_comb begin
    nd_sel = 4'd1;
    for (int i = 0; i < NDIG; i++)
      if (bcd[i] != 4'd0) nd_sel = 4'(i + 1);
  end

  function automatic logic [7:0] byte_at(input logic [3:0] k, input logic [3:0] nd,
                                         input logic [NDIG-1:0][3:0] d);
    logic [3:0] i;
    logic [7:0] b;
    i = 4'd0;
    b = 8'h0A;
    if (k < nd) begin
      i = nd - k - 4'd1;
      b = 8'h30 + {4'h0, d[i]};
    end else if (k == nd) begin
      b = 8'h0D;
    end
    return b;
  endfunction

  // tx/done/busy are registered off the current state, so the line lags the
  // state by one clock; accepting only with busy low keeps start ignored
  // until the done pulse has actually appeared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bin   <= '0;
      bcd   <= '0;
      step  <= '0;
      cnt   <= '0;
      bitn  <= '0;
      bidx  <= '0;
      ndig  <= '0;
      sh    <= '0;
      fin   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      tx    <= 1'b1;
    end else begin
      fin  <= 1'b0;
      done <= fin;
      if (fin) busy <= 1'b0;

      case (state)
        START_BIT: tx <= 1'b0;
        DATA:      tx <= sh[0];
        default:   tx <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          if (start && !busy) begin
            bin   <= score;
            bcd   <= '0;
            step  <= '0;
            busy  <= 1'b1;
            state <= CONVERT;
          end
        end
        CONVERT: begin
          bcd  <= {bcd_flat[4*NDIG-2:0], bin[31]};
          bin  <= {bin[30:0], 1'b0};
          step <= step + 5'd1;
          if (step == 5'd31) state <= SELECT;
        end
        SELECT: begin
          ndig  <= nd_sel;
          bidx  <= '0;
          sh    <= byte_at(4'd0, nd_sel, bcd);
          cnt   <= '0;
          state <= START_BIT;
        end
        START_BIT: begin
          if (bit_end) begin
            cnt   <= '0;
            bitn  <= '0;
            state <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt  <= '0;
            sh   <= {1'b0, sh[7:1]};
            bitn <= bitn + 3'd1;
            if (bitn == 3'd7) state <= STOP_BIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP_BIT: begin
          if (bit_end) begin
            cnt <= '0;
            if (bidx == ndig + 4'd1) begin
              bidx  <= '0;
              fin   <= 1'b1;
              state <= IDLE;
            end else begin
              bidx  <= bidx + 4'd1;
              sh    <= byte_at(bidx + 4'd1, ndig, bcd);
              state <= START_BIT;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_score_uart_tx.sv
// Randomized bench for score_uart_tx: mid-bit UART monitor checked against a
// decimal-string reference model, plus latency, framing, busy and done checks.

module tb_score_uart_tx;
  localparam int CPB = 4;
  localparam int FRM = 10 * CPB;
  localparam int LAT = 34;

  logic        clk, rst_n, start, busy, done, tx;
  logic [31:0] score;

  score_uart_tx #(.CLK_HZ(8), .BAUD(2)) dut (
    .clk(clk), .rst_n(rst_n), .score(score), .start(start),
    .busy(busy), .done(done), .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // reference: decimal digits MSD first, then CR LF
  logic [7:0] exp_q[$];
  function automatic void mk_exp(input logic [31:0] v);
    longint x;
    exp_q.delete();
    x = v;
    if (x == 0) exp_q.push_back(8'h30);
    while (x > 0) begin
      exp_q.push_front(8'(8'h30 + x % 10));
      x = x / 10;
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  int rst_evt = 0;
  always @(negedge rst_n) rst_evt++;

  int done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // UART monitor, samples each bit at its midpoint; frames cut by reset are dropped
  logic [7:0] rx_q[$];
  longint     fall_q[$];
  int         frm_err = 0;
  longint     mon_f;
  int         mon_re;
  logic [7:0] mon_b;
  logic       mon_ok, mon_stop;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        mon_f  = cyc;
        mon_re = rst_evt;
        mon_ok = 1'b1;
        repeat (2) @(negedge clk);
        if (tx !== 1'b0) mon_ok = 1'b0;
        for (int j = 0; j < 8; j++) begin
          repeat (CPB) @(negedge clk);
          mon_b[j] = tx;
        end
        repeat (CPB) @(negedge clk);
        mon_stop = tx;
        if (mon_re == rst_evt) begin
          rx_q.push_back(mon_b);
          fall_q.push_back(mon_f);
          if (!mon_ok || mon_stop !== 1'b1) frm_err++;
        end
      end
    end
  end

  int busy_low = 0;

  task automatic kick(input logic [31:0] v, output longint acc);
    score = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc   = cyc;
    start = 1'b0;
    chk("accept_busy", busy, 1);
  endtask

  task automatic wait_done(input string tag, output longint dc);
    bit ok;
    ok = 1'b0;
    dc = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        dc = cyc;
        chk({tag, "_busy_at_done"}, busy, 0);
      end else if (busy !== 1'b1) begin
        busy_low++;
      end
    end
    chk({tag, "_done_seen"}, ok, 1);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    fall_q.delete();
    done_cnt = 0;
    frm_err  = 0;
    busy_low = 0;
  endtask

  task automatic check_tx(input string tag, input logic [31:0] v, input longint acc,
                          input longint dc);
    int n;
    mk_exp(v);
    n = exp_q.size();
    chk({tag, "_nbytes"}, rx_q.size(), n);
    for (int i = 0; i < n; i++)
      if (i < rx_q.size()) chk({tag, "_byte"}, rx_q[i], exp_q[i]);
    if (fall_q.size() > 0) chk({tag, "_latency"}, fall_q[0] - acc, LAT);
    for (int i = 1; i < fall_q.size(); i++)
      chk({tag, "_gap"}, fall_q[i] - fall_q[i-1], FRM);
    chk({tag, "_done_at"}, dc - acc, LAT + n * FRM);
    chk({tag, "_ndone"}, done_cnt, 1);
    chk({tag, "_framing"}, frm_err, 0);
    chk({tag, "_busy_high"}, busy_low, 0);
    clear_mon();
  endtask

  task automatic one(input string tag, input logic [31:0] v);
    longint acc, dc;
    @(negedge clk);
    kick(v, acc);
    wait_done(tag, dc);
    @(negedge clk);
    check_tx(tag, v, acc, dc);
  endtask

  initial begin
    longint acc, dc, acc2;
    logic [31:0] v;
    rst_n = 1'b0;
    start = 1'b0;
    score = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    one("nominal", 32'd16764);
    one("zero", 32'd0);
    one("max", 32'hFFFF_FFFF);
    for (int i = 0; i < 6; i++) begin
      v = $urandom() >> $urandom_range(0, 31);
      one("rand", v);
    end

    // second start and score change during frame 2 must be ignored
    @(negedge clk);
    kick(32'd16764, acc);
    for (int i = 0; i < 500 && cyc < acc + LAT + FRM + 10; i++) @(negedge clk);
    score = 32'd99;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", dc);
    @(negedge clk);
    check_tx("ignore", 32'd16764, acc, dc);
    repeat (60) @(negedge clk);
    chk("ignore_idle_bytes", rx_q.size(), 0);
    chk("ignore_idle_done", done_cnt, 0);
    one("after_ignore", 32'd99);

    // reset in the middle of frame 3's data bits
    @(negedge clk);
    kick(32'd16764, acc);
    for (int i = 0; i < 500 && cyc < acc + LAT + 2 * FRM + 10; i++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clear_mon();
    one("post_rst", 32'd7);

    // back-to-back: start raised in the done cycle
    @(negedge clk);
    kick(32'd123, acc);
    wait_done("b2b_first", dc);
    kick(32'd5, acc2);
    chk("b2b_accept_edge", acc2 - dc, 1);
    check_tx("b2b_first", 32'd123, acc, dc);
    wait_done("b2b", dc);
    @(negedge clk);
    check_tx("b2b", 32'd5, acc2, dc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
